// File: rtl/simple_router_pkg.sv
// Shared router/merger definitions: port count and the 2-bit port tag type.
package simple_router_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;

  typedef logic [PORT_W-1:0] port_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester at or after ptr, wrapping modulo 4.
module rr_arbiter4
  import simple_router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_t                ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output port_t                gnt_idx,
  output logic                 any
);

  port_t idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      // 2-bit addition wraps naturally, giving the modulo-4 search order
      idx = ptr + port_t'(k);
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt_idx      = idx;
        gnt[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_merger.sv
// 4-to-1 merger: one holding register per source, round-robin onto a registered,
// source-tagged output stage. Idle outputs read as zero.
module simple_merger
  import simple_router_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic                  din0_en,
  input  logic                  din1_en,
  input  logic                  din2_en,
  input  logic                  din3_en,
  output logic                  din0_rdy,
  output logic                  din1_rdy,
  output logic                  din2_rdy,
  output logic                  din3_rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_en,
  output logic [1:0]            addr,
  input  logic                  dout_rdy
);

  logic [NUM_PORTS-1:0]  buf_vld;
  logic [DATA_WIDTH-1:0] buf_data [NUM_PORTS];
  logic                  out_vld;
  logic [DATA_WIDTH-1:0] out_data;
  port_t                 out_addr;
  port_t                 rr_ptr;

  logic [NUM_PORTS-1:0]  din_en_v;
  logic [DATA_WIDTH-1:0] din_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  gnt;
  port_t                 gnt_idx;
  logic                  gnt_any;
  logic                  can_load;

  always_comb begin
    din_arr[0] = din0;
    din_arr[1] = din1;
    din_arr[2] = din2;
    din_arr[3] = din3;
  end

  assign din_en_v = {din3_en, din2_en, din1_en, din0_en};

  // Ready depends only on the holding registers and reset, never on din*_en.
  assign din0_rdy = ~buf_vld[0] & ~rst;
  assign din1_rdy = ~buf_vld[1] & ~rst;
  assign din2_rdy = ~buf_vld[2] & ~rst;
  assign din3_rdy = ~buf_vld[3] & ~rst;

  assign can_load = ~out_vld | dout_rdy;

  rr_arbiter4 u_arb (
    .req     (buf_vld),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) buf_data[i] <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
      rr_ptr   <= '0;
    end else begin
      // A granted buffer had rdy low this cycle, so grant-clear and capture never collide.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (can_load && gnt[i]) begin
          buf_vld[i] <= 1'b0;
        end else if (din_en_v[i] && !buf_vld[i]) begin
          buf_vld[i]  <= 1'b1;
          buf_data[i] <= din_arr[i];
        end
      end
      if (can_load) begin
        if (gnt_any) begin
          out_vld  <= 1'b1;
          out_data <= buf_data[gnt_idx];
          out_addr <= gnt_idx;
          rr_ptr   <= gnt_idx + port_t'(1);
        end else begin
          out_vld  <= 1'b0;
          out_data <= '0;
        end
      end
    end
  end

  assign dout    = out_vld ? out_data : '0;
  assign addr    = out_vld ? out_addr : '0;
  assign dout_en = out_vld;

endmodule

// File: tb/tb_simple_merger.sv
// Bench for simple_merger: per-source scoreboard queues plus table and directed checks.
module tb_simple_merger;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din_d [4];
  logic        en_d  [4];
  logic        rdy0, rdy1, rdy2, rdy3;
  logic [3:0]  rdy_v;
  logic [31:0] dout;
  logic        dout_en;
  logic [1:0]  addr;
  logic        dout_rdy = 1'b1;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int src_cnt [4];

  logic [31:0] exp_q [4][$];
  logic [31:0] tx_q  [4][$];

  typedef struct {
    logic        sink_rdy;
    logic        exp_en;
    logic [1:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t rr_tab [5];

  always #5 clk = ~clk;

  assign rdy_v = {rdy3, rdy2, rdy1, rdy0};

  simple_merger #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .din0     (din_d[0]),
    .din1     (din_d[1]),
    .din2     (din_d[2]),
    .din3     (din_d[3]),
    .din0_en  (en_d[0]),
    .din1_en  (en_d[1]),
    .din2_en  (en_d[2]),
    .din3_en  (en_d[3]),
    .din0_rdy (rdy0),
    .din1_rdy (rdy1),
    .din2_rdy (rdy2),
    .din3_rdy (rdy3),
    .dout     (dout),
    .dout_en  (dout_en),
    .addr     (addr),
    .dout_rdy (dout_rdy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: inputs are sampled mid-cycle, ahead of the edge that will transfer them.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      if (dout_en && dout_rdy) begin
        checks++;
        if (exp_q[addr].size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h on port %0d, expected no word", dout, addr);
        end else begin
          logic [31:0] e;
          e = exp_q[addr].pop_front();
          if (dout !== e) begin
            errors++;
            $display("FAIL order_port%0d: got %h expected %h", addr, dout, e);
          end
        end
        xfer_cnt++;
        src_cnt[addr]++;
      end
      for (int i = 0; i < 4; i++)
        if (en_d[i] && rdy_v[i]) exp_q[i].push_back(din_d[i]);
    end
  end

  task automatic apply_drive();
    for (int i = 0; i < 4; i++) begin
      en_d[i]  = (tx_q[i].size() > 0);
      din_d[i] = (tx_q[i].size() > 0) ? tx_q[i][0] : 32'h0;
    end
  endtask

  task automatic tick();
    logic [3:0] acc;
    #1;
    for (int i = 0; i < 4; i++) acc[i] = en_d[i] && rdy_v[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i] && tx_q[i].size() > 0) void'(tx_q[i].pop_front());
    apply_drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tx_q[i].delete();
    apply_drive();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) src_cnt[i] = 0;
  endtask

  initial begin
    logic [31:0] held;
    int base;
    int guard;

    for (int i = 0; i < 4; i++) begin
      src_cnt[i] = 0;
      en_d[i]    = 1'b1;
      din_d[i]   = 32'hAA00_0000 + i;
    end

    // Reset with every source offering
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_en", {31'b0, dout_en}, 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_addr", {30'b0, addr}, 32'h0);
    check("rst_rdy", {28'b0, rdy_v}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) en_d[i] = 1'b0;
    #1;
    check("post_rst_rdy", {28'b0, rdy_v}, 32'hF);

    // Single source, one cycle after acceptance
    dout_rdy = 1'b1;
    tx_q[2].push_back(32'hDEAD_BEEF);
    apply_drive();
    tick();
    check("single_not_yet", {31'b0, dout_en}, 32'h0);
    tick();
    check("single_en", {31'b0, dout_en}, 32'h1);
    check("single_data", dout, 32'hDEAD_BEEF);
    check("single_addr", {30'b0, addr}, 32'h2);
    tick();
    check("single_idle_en", {31'b0, dout_en}, 32'h0);
    check("single_idle_data", dout, 32'h0);

    // Round-robin from pointer 0, all four loaded on one edge
    do_reset();
    rr_tab[0] = '{1'b1, 1'b1, 2'd0, 32'h10};
    rr_tab[1] = '{1'b1, 1'b1, 2'd1, 32'h11};
    rr_tab[2] = '{1'b1, 1'b1, 2'd2, 32'h12};
    rr_tab[3] = '{1'b1, 1'b1, 2'd3, 32'h13};
    rr_tab[4] = '{1'b1, 1'b0, 2'd0, 32'h0};
    for (int i = 0; i < 4; i++) tx_q[i].push_back(32'h10 + i);
    apply_drive();
    tick();
    for (int v = 0; v < 5; v++) begin
      dout_rdy = rr_tab[v].sink_rdy;
      tick();
      check($sformatf("rr%0d_en", v), {31'b0, dout_en}, {31'b0, rr_tab[v].exp_en});
      check($sformatf("rr%0d_addr", v), {30'b0, addr}, {30'b0, rr_tab[v].exp_addr});
      check($sformatf("rr%0d_data", v), dout, rr_tab[v].exp_data);
    end

    // Pointer wrapped to 0: ports 3 and 1 reloaded leave as 1 then 3
    tx_q[3].push_back(32'h23);
    tx_q[1].push_back(32'h21);
    apply_drive();
    tick();
    tick();
    check("wrap_addr_a", {30'b0, addr}, 32'h1);
    check("wrap_data_a", dout, 32'h21);
    tick();
    check("wrap_addr_b", {30'b0, addr}, 32'h3);
    check("wrap_data_b", dout, 32'h23);
    tick();
    check("wrap_idle", {31'b0, dout_en}, 32'h0);

    // Backpressure: two words per source with the sink stalled
    do_reset();
    dout_rdy = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) tx_q[i].push_back(32'hB000_0000 | (i << 4) | k);
    apply_drive();
    repeat (6) tick();
    check("bp_rdy", {28'b0, rdy_v}, 32'h0);
    check("bp_en", {31'b0, dout_en}, 32'h1);
    check("bp_addr", {30'b0, addr}, 32'h0);
    check("bp_data", dout, 32'hB000_0000);
    check("bp_pending_p1", tx_q[1].size(), 32'd1);
    held = dout;
    tick();
    tick();
    check("bp_stable", dout, held);
    base = xfer_cnt;
    dout_rdy = 1'b1;
    guard = 0;
    while (xfer_cnt < base + 8 && guard < 50) begin
      tick();
      guard++;
    end
    check("bp_drained", xfer_cnt - base, 32'd8);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_src%0d_cnt", i), src_cnt[i], 32'd2);

    // Continuous traffic on sources 0 and 1
    do_reset();
    dout_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tx_q[0].push_back(32'hC000_0000 + k);
      tx_q[1].push_back(32'hC100_0000 + k);
    end
    apply_drive();
    tick();
    tick();
    for (int c = 0; c < 20; c++) begin
      check($sformatf("cont%0d_en", c), {31'b0, dout_en}, 32'h1);
      check($sformatf("cont%0d_addr", c), {30'b0, addr}, c % 2);
      tick();
    end
    check("cont_src0_cnt", src_cnt[0], 32'd10);
    check("cont_src1_cnt", src_cnt[1], 32'd10);

    // Reset while full and presenting a word
    do_reset();
    dout_rdy = 1'b0;
    tx_q[0].push_back(32'hD000_0000);
    tx_q[0].push_back(32'hD000_0001);
    for (int i = 1; i < 4; i++) tx_q[i].push_back(32'hD000_0000 | (i << 4));
    apply_drive();
    repeat (4) tick();
    check("mid_full_en", {31'b0, dout_en}, 32'h1);
    check("mid_full_rdy", {28'b0, rdy_v}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tx_q[i].delete();
    apply_drive();
    tick();
    check("mid_rst_en", {31'b0, dout_en}, 32'h0);
    check("mid_rst_dout", dout, 32'h0);
    check("mid_rst_addr", {30'b0, addr}, 32'h0);
    check("mid_rst_rdy", {28'b0, rdy_v}, 32'h0);
    rst = 1'b0;
    dout_rdy = 1'b1;
    base = xfer_cnt;
    repeat (5) begin
      tick();
      check("mid_after_en", {31'b0, dout_en}, 32'h0);
    end
    check("mid_no_words", xfer_cnt - base, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
